// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the multiply/divide unit.
//   muldiv_op_t    : 3-bit request opcode (values 6/7 are illegal and never accepted)
//   muldiv_state_t : sequencer state
package muldiv_unit_pkg;

  localparam int unsigned MULDIV_DIV_STEPS = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between execute (master) and the multiply/divide unit (slave).
//   req_valid/req_ready/req_op/req_a/req_b : request handshake and operands
//   flush                                 : cancel current/in-flight request
//   hi/lo                                 : architectural HI/LO
//   busy/done                             : stall indication and one-cycle commit pulse
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  muldiv_op_t  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, hi, lo, busy, done
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_unit_div_radix2_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i/quot_i : partial remainder and dividend/quotient shift register
//   dvsr_i       : divisor magnitude
//   rem_o/quot_o : state after shifting in one dividend bit and trial subtract
module muldiv_unit_div_radix2_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] dvsr_i,
  output logic [31:0] rem_o,
  output logic [31:0] quot_o
);

  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    shifted = {rem_i, quot_i[31]};
    // rem_i < dvsr_i, so the trial result lies in (-dvsr, dvsr) and bit 32 is its sign.
    trial   = shifted - {1'b0, dvsr_i};
    rem_o   = trial[32] ? shifted[31:0] : trial[31:0];
    quot_o  = {quot_i[30:0], ~trial[32]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk, resetn : clock and asynchronous active-low reset
//   bus         : muldiv_unit_if.slave (request handshake, flush, hi/lo, busy, done)
// Optional feature macro: MULDIV_DIV_ZERO_FAST_EN -- divide by zero commits on the
// accept edge instead of running the full iteration sequence.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_STEPS  = MULDIV_DIV_STEPS
) (
  input logic            clk,
  input logic            resetn,
  muldiv_unit_if.slave   bus
);

  localparam logic [5:0] MulCntInit = (MUL_STAGES > 1) ? 6'(MUL_STAGES - 2) : 6'd0;
  localparam logic [5:0] DivCntInit = 6'(DIV_STEPS - 1);

  muldiv_state_t state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic [63:0]   prod_q, prod_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic          div_zero_q, div_zero_d;

  logic          accept, op_legal, op_signed, fast_zero;
  logic [63:0]   ext_a, ext_b, product;
  logic [31:0]   mag_a, mag_b, quot_fix, rem_fix;
  logic [31:0]   step_rem, step_quot;

  muldiv_unit_div_radix2_step u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  always_comb begin
    op_legal  = bus.req_op inside {OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo};
    op_signed = (bus.req_op == OpMult) || (bus.req_op == OpDiv);
    accept    = bus.req_valid && (state_q == StIdle) && !bus.flush && op_legal;
    // Sign-extend to 64 bits; the low 64 bits of the product are then correct for both signs.
    ext_a     = {{32{op_signed & bus.req_a[31]}}, bus.req_a};
    ext_b     = {{32{op_signed & bus.req_b[31]}}, bus.req_b};
    product   = ext_a * ext_b;
    mag_a     = (op_signed & bus.req_a[31]) ? (~bus.req_a + 32'd1) : bus.req_a;
    mag_b     = (op_signed & bus.req_b[31]) ? (~bus.req_b + 32'd1) : bus.req_b;
    quot_fix  = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
    rem_fix   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
`ifdef MULDIV_DIV_ZERO_FAST_EN
    fast_zero = (bus.req_b == 32'd0);
`else
    fast_zero = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.req_op)
            OpMult, OpMultu: begin
              if (MUL_STAGES == 1) begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
              end else begin
                prod_d  = product;
                cnt_d   = MulCntInit;
                state_d = StMul;
              end
            end
            OpDiv, OpDivu: begin
              if (fast_zero) begin
                hi_d   = bus.req_a;
                lo_d   = '1;
                done_d = 1'b1;
              end else begin
                rem_d      = '0;
                quot_d     = mag_a;
                dvsr_d     = mag_b;
                neg_quot_d = op_signed & (bus.req_a[31] ^ bus.req_b[31]);
                neg_rem_d  = op_signed & bus.req_a[31];
                div_zero_d = (bus.req_b == 32'd0);
                cnt_d      = DivCntInit;
                state_d    = StDiv;
              end
            end
            OpMthi: begin
              hi_d   = bus.req_a;
              done_d = 1'b1;
            end
            OpMtlo: begin
              lo_d   = bus.req_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (cnt_q == 6'd0) begin
          {hi_d, lo_d} = prod_q;
          done_d       = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StDiv: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          if (cnt_q == 6'd0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          // Divide by zero: all quotient bits saturate and the sign-fixed remainder is a.
          hi_d    = rem_fix;
          lo_d    = div_zero_q ? '1 : quot_fix;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int MulStages = 2;
  localparam int MulBusy   = MulStages - 1;
  localparam int DivBusy   = 33;
`ifdef MULDIV_DIV_ZERO_FAST_EN
  localparam int DivZeroBusy = 0;
`else
  localparam int DivZeroBusy = 33;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if bus();

  muldiv_unit #(
    .MUL_STAGES (MulStages)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    tick();
    // Scribble operands to show they were latched at accept.
    bus.req_valid = 1'b0;
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int busy_n);
    busy_n = 0;
    for (int n = 0; n < 200 && !bus.done; n++) begin
      if (bus.busy) busy_n++;
      tick();
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      if (bus.done) pulses++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_busy);
    int bn;
    issue(op, a, b);
    wait_done(bn);
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_busy_cycles"}, bn, exp_busy);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_ready"}, 32'(bus.req_ready), 1);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  initial begin
    int pulses;
    int bn;
    bus.req_valid = 1'b0;
    bus.req_op    = OpMthi;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.flush     = 1'b0;

    #1;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Load HI/LO, then reset in the middle of a divide.
    run_op("mthi", OpMthi, 32'h0000_AAAA, 32'h0, 32'h0000_AAAA, 32'h0, 0);
    run_op("mtlo", OpMtlo, 32'h0000_5555, 32'h0, 32'h0000_AAAA, 32'h0000_5555, 0);
    issue(OpDiv, 32'd100, 32'd7);
    repeat (9) tick();
    resetn = 1'b0;
    #1;
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    check("midrst_ready", 32'(bus.req_ready), 1);
    check("midrst_done", 32'(bus.done), 0);
    tick();
    resetn = 1'b1;
    count_done(40, pulses);
    check("midrst_no_done", pulses, 0);

    run_op("mult", OpMult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MulBusy);
    run_op("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           MulBusy);
    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivBusy);
    run_op("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DivBusy);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivBusy);
    run_op("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivBusy);
    run_op("divu_z", OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DivZeroBusy);
    run_op("div_z", OpDiv, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, DivZeroBusy);

    // Illegal opcode is never accepted.
    bus.req_valid = 1'b1;
    bus.req_op    = muldiv_op_t'(3'd6);
    bus.req_a     = 32'h1111_1111;
    tick();
    bus.req_valid = 1'b0;
    check("illegal_ready", 32'(bus.req_ready), 1);
    check("illegal_done", 32'(bus.done), 0);
    check("illegal_hi", bus.hi, 32'hFFFF_FFF8);

    // Flush beats accept in IDLE.
    bus.req_valid = 1'b1;
    bus.req_op    = OpMthi;
    bus.req_a     = 32'h99;
    bus.flush     = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    check("idle_flush_done", 32'(bus.done), 0);
    check("idle_flush_hi", bus.hi, 32'hFFFF_FFF8);

    // Flush mid-divide.
    run_op("mthi2", OpMthi, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 0);
    issue(OpDiv, 32'd50, 32'd3);
    repeat (18) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("divflush_ready", 32'(bus.req_ready), 1);
    check("divflush_done", 32'(bus.done), 0);
    check("divflush_hi", bus.hi, 32'h1234);
    check("divflush_lo", bus.lo, 32'hFFFF_FFFF);
    count_done(40, pulses);
    check("divflush_no_done", pulses, 0);

    // Flush coinciding with the multiply commit edge.
    issue(OpMult, 32'd2, 32'd3);
    repeat (MulStages - 2) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("mulflush_done", 32'(bus.done), 0);
    check("mulflush_lo", bus.lo, 32'hFFFF_FFFF);
    check("mulflush_hi", bus.hi, 32'h1234);
    check("mulflush_ready", 32'(bus.req_ready), 1);

    // Back-to-back: new request accepted in the done cycle.
    issue(OpMultu, 32'd6, 32'd7);
    wait_done(bn);
    check("b2b_done", 32'(bus.done), 1);
    check("b2b_ready_at_done", 32'(bus.req_ready), 1);
    check("b2b_lo", bus.lo, 32'd42);
    bus.req_valid = 1'b1;
    bus.req_op    = OpMtlo;
    bus.req_a     = 32'h42;
    tick();
    bus.req_valid = 1'b0;
    check("b2b_mtlo_done", 32'(bus.done), 1);
    check("b2b_mtlo_lo", bus.lo, 32'h42);
    check("b2b_mtlo_hi", bus.hi, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
